// File: rtl/nukv_privacy_pkg.sv
// Shared definitions for the rotated-perturbation stream (transmitter and receiver).
// Holds the receiver state encoding and the trailer framing defaults.
package nukv_privacy_pkg;

    // Receiver position within a packet group.
    typedef enum logic {
        RX_DATA    = 1'b0,
        RX_TRAILER = 1'b1
    } rx_state_t;

    // Value carried in data[7:0] of every trailer beat.
    localparam logic [7:0] ROT_MARKER = 8'h08;

    // Number of single-beat trailer packets following each data packet.
    localparam int ROT_TRAILER_BEATS = 2;

    // Trailer index width; covers the 1..15 trailer-beat range.
    localparam int RX_IDX_WIDTH = 4;

endpackage

// File: rtl/nukv_axis_reg_slice.sv
// Single-stage valid/ready register slice.
// Full throughput: a held beat may drain and a new beat load in the same cycle.
module nukv_axis_reg_slice #(
    parameter int WIDTH = 513
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    // Accept whenever the stage is empty or is being emptied this cycle.
    assign in_ready = !out_valid || out_ready;

    // Hold register: load on accept, otherwise clear valid once drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            // NOTE: the data register is reset as well so the output bus reads zero
            // after reset; downstream sees a defined value, not leftover payload.
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            // NOTE: non-blocking assignments keep every register update based on
            // values from before the clock edge, so ordering here does not matter.
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nukv_rotation_receiver.sv
// Receive end of the rotated-perturbation stream.
// Forwards each data packet through a register slice, consumes and checks the
// marker trailer that follows it, and reports malformed trailer beats.
// Optional statistics (pkt_count, beat_count): define NUKV_ROTATION_RX_STATS_EN.
module nukv_rotation_receiver
    import nukv_privacy_pkg::*;
#(
    parameter int         DATA_WIDTH    = 512,
    parameter logic [7:0] MARKER        = ROT_MARKER,
    parameter int         TRAILER_BEATS = ROT_TRAILER_BEATS,
    parameter int         CNT_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic                  input_valid,
    input  logic                  input_last,
    output logic                  input_ready,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_valid,
    output logic                  output_last,
    input  logic                  output_ready,
    output logic                  err_marker,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  beat_count
);

    localparam logic [RX_IDX_WIDTH-1:0] LAST_IDX = RX_IDX_WIDTH'(TRAILER_BEATS - 1);

    rx_state_t               state, state_next;
    logic [RX_IDX_WIDTH-1:0] idx, idx_next;
    logic                    hs;
    logic                    trailer_good;
    logic                    fwd;
    logic                    err_set;
    logic                    slice_ready;
    logic [DATA_WIDTH:0]     slice_out;

    // Ready depends only on the output stage, never on input_valid.
    assign input_ready  = slice_ready;
    assign hs           = input_valid && input_ready;
    assign trailer_good = input_last
                       && (input_data[7:0] == MARKER)
                       && (input_data[DATA_WIDTH-1:8] == '0);

    nukv_axis_reg_slice #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_slice (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (fwd),
        .in_data   ({input_last, input_data}),
        .in_ready  (slice_ready),
        .out_valid (output_valid),
        .out_data  (slice_out),
        .out_ready (output_ready)
    );

    assign output_last = slice_out[DATA_WIDTH];
    assign output_data = slice_out[DATA_WIDTH-1:0];

    // State and trailer index register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RX_DATA;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next-state, forward and error decisions, taken only on an input handshake.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_next = state;
        idx_next   = idx;
        fwd        = 1'b0;
        err_set    = 1'b0;
        if (hs) begin
            case (state)
                RX_DATA: begin
                    fwd = 1'b1;
                    if (input_last) begin
                        state_next = RX_TRAILER;
                        idx_next   = '0;
                    end
                end
                RX_TRAILER: begin
                    if (trailer_good) begin
                        if (idx == LAST_IDX) begin
                            state_next = RX_DATA;
                            idx_next   = '0;
                        end else begin
                            idx_next = idx + 1'b1;
                        end
                    end else begin
                        // Resync: the bad beat opens the next data packet.
                        err_set    = 1'b1;
                        fwd        = 1'b1;
                        idx_next   = '0;
                        state_next = input_last ? RX_TRAILER : RX_DATA;
                    end
                end
                default: begin
                    state_next = RX_DATA;
                    idx_next   = '0;
                end
            endcase
        end
    end

    // Error pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_marker <= 1'b0;
            err_count  <= '0;
        end else begin
            err_marker <= err_set;
            if (err_set && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

`ifdef NUKV_ROTATION_RX_STATS_EN
    logic pkt_inc;
    logic [CNT_WIDTH-1:0] pkt_count_q;
    logic [CNT_WIDTH-1:0] beat_count_q;

    assign pkt_inc = hs && (state == RX_TRAILER) && trailer_good && (idx == LAST_IDX);

    // Statistics counters; both wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_count_q  <= '0;
            beat_count_q <= '0;
        end else begin
            if (pkt_inc) begin
                pkt_count_q <= pkt_count_q + 1'b1;
            end
            if (fwd) begin
                beat_count_q <= beat_count_q + 1'b1;
            end
        end
    end

    assign pkt_count  = pkt_count_q;
    assign beat_count = beat_count_q;
`else
    assign pkt_count  = '0;
    assign beat_count = '0;
`endif

endmodule
